// File: rtl/ins_mem_pkg.sv
// Shared widths, response-entry layout and parity helper for the instruction memory prefetcher.
// Entry fields are sized for the widest supported build; narrower instances leave upper bits at zero.
package ins_mem_pkg;
   localparam int DEF_DATA_W = 19;
   localparam int DEF_ADDR_W = 19;
   localparam int MAX_DATA_W = 64;
   localparam int MAX_ADDR_W = 64;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] data;
      logic [MAX_ADDR_W-1:0] addr;
      logic                  perr;
   } rsp_entry_t;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/ins_mem_array.sv
// Synchronous 1W/1R instruction RAM with write-first bypass; contents are never reset.
module ins_mem_array #(
   parameter int WORD_W = 19,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [WORD_W-1:0] i_wr_word,
   input  logic              i_rd_en,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [WORD_W-1:0] o_rd_word
);
   localparam int WORDS = 1 << IDX_W;

   logic [WORD_W-1:0] r_mem [WORDS];
   logic [WORD_W-1:0] r_rd_word;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_word;
      if (i_rd_en) r_rd_word <= (i_wr_en && (i_wr_idx == i_rd_idx)) ? i_wr_word : r_mem[i_rd_idx];
   end

   assign o_rd_word = r_rd_word;
endmodule

// File: rtl/ins_mem_pf.sv
// Instruction memory with a one-cycle fetch pipeline feeding an in-order response buffer.
// Define INS_MEM_PARITY_EN to store an even-parity bit per word and expose parity_err.
module ins_mem_pf
   import ins_mem_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DEPTH     = 2**ADDR_W,
   parameter int RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr
`ifdef INS_MEM_PARITY_EN
   ,output logic             parity_err
`endif
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int LVL_W = CNT_W + 1;
`ifdef INS_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic              r_live;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflight_addr;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   rsp_entry_t        r_buf [RSP_DEPTH];

   logic              w_accept;
   logic              w_pop;
   logic [LVL_W-1:0]  w_level;
   logic [MEM_W-1:0]  w_wr_word;
   logic [MEM_W-1:0]  w_rd_word;
   rsp_entry_t        w_cap;
   rsp_entry_t        w_head;
   logic              w_unused;

`ifdef INS_MEM_PARITY_EN
   assign w_wr_word = {even_parity(MAX_DATA_W'(wr_data)), wr_data};
`else
   assign w_wr_word = wr_data;
`endif

   ins_mem_array #(.WORD_W(MEM_W), .IDX_W(IDX_W)) u_array (
      .clk       (clk),
      .i_wr_en   (wr_en),
      .i_wr_idx  (wr_addr[IDX_W-1:0]),
      .i_wr_word (w_wr_word),
      .i_rd_en   (w_accept),
      .i_rd_idx  (req_addr[IDX_W-1:0]),
      .o_rd_word (w_rd_word)
   );

   // Level counts the slot reserved by the fetch still in the RAM read stage.
   assign w_pop    = rsp_valid & rsp_ready;
   assign w_level  = LVL_W'(r_count) + LVL_W'(r_inflight) - LVL_W'(w_pop);
   assign req_ready = r_live & (w_level < LVL_W'(RSP_DEPTH));
   assign w_accept = req_valid & req_ready;

   always_comb begin
      w_cap      = '0;
      w_cap.data = MAX_DATA_W'(w_rd_word[DATA_W-1:0]);
      w_cap.addr = MAX_ADDR_W'(r_inflight_addr);
`ifdef INS_MEM_PARITY_EN
      w_cap.perr = even_parity(w_cap.data) ^ w_rd_word[DATA_W];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live          <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_addr <= '0;
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
      end else begin
         r_live     <= 1'b1;
         r_inflight <= w_accept;
         if (w_accept) r_inflight_addr <= req_addr;
         if (r_inflight) r_tail <= (r_tail == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_tail + 1'b1;
         if (w_pop) r_head <= (r_head == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_head + 1'b1;
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Buffer payload needs no reset; outputs are masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (r_inflight) r_buf[r_tail] <= w_cap;
   end

   assign w_head    = r_buf[r_head];
   assign rsp_valid = (r_count != '0);
   assign rsp_data  = rsp_valid ? w_head.data[DATA_W-1:0] : '0;
   assign rsp_addr  = rsp_valid ? w_head.addr[ADDR_W-1:0] : '0;
`ifdef INS_MEM_PARITY_EN
   assign parity_err = rsp_valid & w_head.perr;
`endif

   assign w_unused = ^{w_head, wr_addr};
endmodule

// File: tb/tb_ins_mem_pf.sv
// Directed self-checking bench for ins_mem_pf (DEPTH=16, RSP_DEPTH=2).
module tb_ins_mem_pf;
   localparam int DW = 19;
   localparam int AW = 19;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
`ifdef INS_MEM_PARITY_EN
   logic          parity_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   ins_mem_pf #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .RSP_DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr)
`ifdef INS_MEM_PARITY_EN
      ,.parity_err(parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 19'd0; wr_data = 19'h00001;
      req_valid = 1'b1; req_addr = 19'd0; rsp_ready = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
      n_checks++;
      if (rsp_data !== '0 || rsp_addr !== '0) begin
         n_errors++; $display("FAIL reset_rsp_payload got=%h/%h exp=0/0", rsp_data, rsp_addr);
      end
      wr_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin n_errors++; $display("FAIL release_before_edge_req_ready got=%0b exp=0", req_ready); end
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL release_req_ready got=%0b exp=1", req_ready); end
   endtask

   task automatic test_write_fetch();
      write_word(19'd5, 19'h01234);
      req_valid = 1'b1; req_addr = 19'd5;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL fetch_latency_early got=%0b exp=0", rsp_valid); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h01234 || rsp_addr !== 19'd5) begin
         n_errors++; $display("FAIL fetch_basic got=%0b/%h/%0d exp=1/01234/5", rsp_valid, rsp_data, rsp_addr);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL pop_to_empty got=%0b exp=0", rsp_valid); end
   endtask

   task automatic test_write_first();
      write_word(19'd9, 19'h00055);
      wr_en = 1'b1; wr_addr = 19'd9; wr_data = 19'h7FFFF;
      req_valid = 1'b1; req_addr = 19'd9;
      tick();
      wr_en = 1'b0; req_valid = 1'b0;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h7FFFF || rsp_addr !== 19'd9) begin
         n_errors++; $display("FAIL write_first got=%0b/%h/%0d exp=1/7ffff/9", rsp_valid, rsp_data, rsp_addr);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_wrap();
      write_word(19'd3, 19'h00ABC);
      req_valid = 1'b1; req_addr = 19'd19;
      tick();
      req_addr = 19'h40003;
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h00ABC || rsp_addr !== 19'd19) begin
         n_errors++; $display("FAIL wrap_19 got=%0b/%h/%h exp=1/00abc/13", rsp_valid, rsp_data, rsp_addr);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h00ABC || rsp_addr !== 19'h40003) begin
         n_errors++; $display("FAIL wrap_high got=%0b/%h/%h exp=1/00abc/40003", rsp_valid, rsp_data, rsp_addr);
      end
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_drain got=%0b exp=0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      write_word(19'd1, 19'h00111);
      write_word(19'd2, 19'h00222);
      write_word(19'd3, 19'h00333);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 19'd1;
      tick();
      req_addr = 19'd2;
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_second_ready got=%0b exp=1", req_ready); end
      tick();
      req_addr = 19'd3;
      n_checks++;
      if (req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_third_blocked got=%0b exp=0", req_ready); end
      tick();
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 19'h00111 || rsp_addr !== 19'd1) begin
         n_errors++; $display("FAIL bp_full_head got=%0b/%0b/%h/%0d exp=0/1/00111/1", req_ready, rsp_valid, rsp_data, rsp_addr);
      end
      tick();
      n_checks++;
      if (rsp_data !== 19'h00111 || rsp_addr !== 19'd1 || req_ready !== 1'b0) begin
         n_errors++; $display("FAIL bp_stable got=%h/%0d/%0b exp=00111/1/0", rsp_data, rsp_addr, req_ready);
      end
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_on_pop got=%0b exp=1", req_ready); end
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h00222 || rsp_addr !== 19'd2) begin
         n_errors++; $display("FAIL bp_second_rsp got=%0b/%h/%0d exp=1/00222/2", rsp_valid, rsp_data, rsp_addr);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h00333 || rsp_addr !== 19'd3) begin
         n_errors++; $display("FAIL bp_third_rsp got=%0b/%h/%0d exp=1/00333/3", rsp_valid, rsp_data, rsp_addr);
      end
      tick();
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_errors++; $display("FAIL bp_empty_pop got=%0b/%0b exp=0/1", rsp_valid, req_ready);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_d [3];
      exp_d[0] = 19'h00111; exp_d[1] = 19'h00222; exp_d[2] = 19'h00333;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 19'd1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) begin
            req_addr = AW'(i + 2);
            n_checks++;
            if (req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d got=%0b exp=1", i, req_ready); end
         end else begin
            req_valid = 1'b0;
         end
         tick();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_d[i] || rsp_addr !== AW'(i + 1)) begin
            n_errors++; $display("FAIL b2b_rsp_%0d got=%0b/%h/%0d exp=1/%h/%0d", i, rsp_valid, rsp_data, rsp_addr, exp_d[i], i + 1);
         end
      end
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%0b exp=0", rsp_valid); end
   endtask

   task automatic test_reset_midop();
      req_valid = 1'b1; req_addr = 19'd1;
      tick();
      req_addr = 19'd2;
      tick();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== '0) begin
         n_errors++; $display("FAIL midop_reset got=%0b/%0b/%h exp=0/0/0", rsp_valid, req_ready, rsp_data);
      end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_errors++; $display("FAIL midop_discard got=%0b/%0b exp=0/1", rsp_valid, req_ready);
      end
      req_valid = 1'b1; req_addr = 19'd5;
      tick();
      req_valid = 1'b0;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'h01234) begin
         n_errors++; $display("FAIL mem_retained got=%0b/%h exp=1/01234", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

`ifdef INS_MEM_PARITY_EN
   task automatic test_parity();
      write_word(19'd7, 19'h00F0F);
      write_word(19'd8, 19'h00F0E);
      dut.u_array.r_mem[7] = dut.u_array.r_mem[7] ^ 20'h00001;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 19'd7;
      tick();
      req_addr = 19'd8;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || parity_err !== 1'b1 || rsp_addr !== 19'd7) begin
         n_errors++; $display("FAIL parity_bad got=%0b/%0b/%0d exp=1/1/7", rsp_valid, parity_err, rsp_addr);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || parity_err !== 1'b0 || rsp_data !== 19'h00F0E) begin
         n_errors++; $display("FAIL parity_good got=%0b/%0b/%h exp=1/0/00f0e", rsp_valid, parity_err, rsp_data);
      end
      tick();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      test_reset();
      test_write_fetch();
      test_write_first();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
`ifdef INS_MEM_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/ins_mem_pf.md
INS_MEM_PF -- requirements
Module: ins_mem_pf

Interface
REQ-001 Parameter DATA_W, default 19, SHALL set the instruction word width in bits.
REQ-002 Parameter ADDR_W, default 19, SHALL set the address port width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W, SHALL set the word count; it SHALL be a power of two and no greater than 2**ADDR_W.
REQ-004 Parameter RSP_DEPTH, default 2, SHALL set the response buffer depth in entries; its minimum is 2.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 wr_en  in  1  write strobe for the loader port.
REQ-008 wr_addr  in  ADDR_W  write word address.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 req_valid  in  1  fetch request valid.
REQ-011 req_ready  out  1  fetch request accepted on this edge when req_valid is also high.
REQ-012 req_addr  in  ADDR_W  fetch word address.
REQ-013 rsp_valid  out  1  response buffer head valid.
REQ-014 rsp_ready  in  1  consumer pops the head on this edge.
REQ-015 rsp_data  out  DATA_W  fetched instruction word.
REQ-016 rsp_addr  out  ADDR_W  address of rsp_data, as originally requested (untruncated).
REQ-017 parity_err  out  1  head word failed its parity check (present only with INS_MEM_PARITY_EN).

Function
REQ-018 Write and fetch ports SHALL be independent, so a write and a fetch accepted on the same edge both take effect.
REQ-019 Only the low log2(DEPTH) address bits SHALL index memory, and higher bits SHALL be ignored (wrap-around).
REQ-020 A fetch accepted at edge N SHALL have its data captured at edge N+1; rsp_valid SHALL rise after edge N+1 if the buffer was empty.
REQ-021 A fetch and a write to the same index on the same edge SHALL return the newly written data (write-first).
REQ-022 req_ready SHALL be high iff (occupancy + in_flight - pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready; this allows one fetch per cycle when rsp_ready is held high.
REQ-023 Responses SHALL be delivered in request order, and the buffer SHALL never overflow or drop a response.
REQ-024 rsp_data and rsp_addr SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-025 When the buffer is full, a capture and a pop on the same edge SHALL leave occupancy unchanged.
REQ-026 rsp_valid SHALL be low when the buffer is empty, and a pop while empty SHALL be ignored.

Reset
REQ-027 While rst_n is low: req_ready=0, rsp_valid=0, occupancy=0, in_flight=0, rsp_data=0, rsp_addr=0, parity_err=0.
REQ-028 req_ready SHALL be 1 from the first clock edge after rst_n is released.
REQ-029 Assertion of reset mid-operation SHALL discard in-flight fetches and all buffered responses.
REQ-030 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With INS_MEM_PARITY_EN defined, each stored word SHALL carry one even-parity bit computed at write time.
REQ-032 With INS_MEM_PARITY_EN defined, parity_err SHALL be set with the affected head entry and shall travel with it.
REQ-033 With INS_MEM_PARITY_EN undefined, neither the parity storage nor the parity_err port SHALL exist.

Structure
REQ-034 Package ins_mem_pkg SHALL hold the default widths, the response-entry struct typedef {data, addr, perr}, and the parity function.
REQ-035 The storage SHALL be a sub-module ins_mem_array: synchronous 1W/1R RAM with write-first bypass and no reset.

Verification
REQ-036 Reset with rst_n=0 and the bus active -> all outputs 0; one edge after release, req_ready=1.
REQ-037 Write 0x1234 at address 5, then fetch address 5 -> rsp_valid one cycle later with rsp_data=0x1234 and rsp_addr=5.
REQ-038 Write 0x7FFFF at address 9 and fetch address 9 on the same edge -> rsp_data=0x7FFFF.
REQ-039 With DEPTH=16, write 0xABC at address 3, then fetch address 19 -> rsp_data=0xABC and rsp_addr=19.
REQ-040 rsp_ready=0, then fetch addresses 1, 2, 3 back-to-back -> only 2 accepted, req_ready=0; release rsp_ready -> data for 1 then 2, in order, with no loss, then 3 accepted.
REQ-041 With INS_MEM_PARITY_EN, force-flip one stored bit at address 7 and fetch address 7 -> parity_err=1 with that response; a fetch of address 8 -> parity_err=0.
